// File: rtl/npu_pkg.sv
// Shared NPU definitions: accumulator width helper and default buffer sizing.
package npu_pkg;

  localparam int OUT_FIFO_DEPTH = 8;

  // Accumulator/result word width for an N x N systolic array.
  function automatic int acc_w(input int n);
    return 16 + n - 1;
  endfunction

endpackage

// File: rtl/npu_out_fifo_if.sv
// Write/read port bundle for the ReLU output FIFO.
interface npu_out_fifo_if
  import npu_pkg::*;
#(
  parameter int N     = 2,
  parameter int DEPTH = OUT_FIFO_DEPTH
);
  localparam int W  = acc_w(N);
  localparam int CW = $clog2(DEPTH) + 1;

  logic          clr;
  logic          wr_en;
  logic [W-1:0]  wr_data;
  logic          rd_ready;
  logic          rd_valid;
  logic [W-1:0]  rd_data;
  logic [CW-1:0] count;
  logic          full;
  logic          empty;
  logic          overflow;
  logic          frame_done;

  // Producer/consumer side.
  modport master (
    output clr, wr_en, wr_data, rd_ready,
    input  rd_valid, rd_data, count, full, empty, overflow, frame_done
  );

  // FIFO side.
  modport slave (
    input  clr, wr_en, wr_data, rd_ready,
    output rd_valid, rd_data, count, full, empty, overflow, frame_done
  );
endinterface

// File: rtl/npu_out_fifo_frame_counter.sv
// Modulo-F strobe counter; pulses done_o one cycle after the F-th strobe.
module npu_frame_counter #(
  parameter int F = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic strobe_i,
  output logic done_o
);
  localparam int FCW = (F > 1) ? $clog2(F) : 1;

  logic [FCW-1:0] fc_q, fc_d;
  logic           done_q, done_d;
  logic           last;

  assign last = (fc_q == FCW'(F - 1));

  // Next state: every strobe counts, wrapping on the last word of a frame.
  always_comb begin
    fc_d   = fc_q;
    done_d = 1'b0;
    if (clr_i) begin
      fc_d = '0;
    end else if (strobe_i) begin
      fc_d   = last ? '0 : fc_q + FCW'(1);
      done_d = last;
    end
  end

  // Counter and registered done pulse.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fc_q   <= '0;
      done_q <= 1'b0;
    end else begin
      fc_q   <= fc_d;
      done_q <= done_d;
    end
  end

  assign done_o = done_q;
endmodule

// File: rtl/npu_out_fifo.sv
// FWFT circular output buffer behind the ReLU stage with frame tracking
// and sticky overflow on dropped writes.
module npu_out_fifo
  import npu_pkg::*;
#(
  parameter int N     = 2,
  parameter int DEPTH = OUT_FIFO_DEPTH
) (
  input logic           clk,
  input logic           rst,
  npu_out_fifo_if.slave bus
);
  localparam int W  = acc_w(N);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int F  = 2 * N;

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wp_q, wp_d, rp_q, rp_d;
  logic [CW-1:0] count_q, count_d;
  logic          ovf_q, ovf_d;
  logic          full, empty, rd_fire, wr_acc, wr_drop;

  assign full    = (count_q == CW'(DEPTH));
  assign empty   = (count_q == '0);
  assign rd_fire = !empty && bus.rd_ready;
  // A full buffer still accepts a write when the head leaves the same cycle.
  assign wr_acc  = bus.wr_en && (!full || rd_fire);
  assign wr_drop = bus.wr_en && full && !rd_fire;

  // Pointer/occupancy/overflow next state; clr overrides traffic.
  always_comb begin
    wp_d    = wp_q;
    rp_d    = rp_q;
    count_d = count_q;
    ovf_d   = ovf_q;
    if (bus.clr) begin
      wp_d    = '0;
      rp_d    = '0;
      count_d = '0;
      ovf_d   = 1'b0;
    end else begin
      if (wr_acc)  wp_d = wp_q + AW'(1);
      if (rd_fire) rp_d = rp_q + AW'(1);
      if (wr_acc && !rd_fire)      count_d = count_q + CW'(1);
      else if (!wr_acc && rd_fire) count_d = count_q - CW'(1);
      if (wr_drop) ovf_d = 1'b1;
    end
  end

  // Control state registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wp_q    <= '0;
      rp_q    <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      wp_q    <= wp_d;
      rp_q    <= rp_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
    end
  end

  // Storage; zeroed on reset so the head reads 0, untouched by clr.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (!bus.clr && wr_acc) begin
      mem_q[wp_q] <= bus.wr_data;
    end
  end

  // Framing follows every producer strobe, dropped or not.
  npu_frame_counter #(.F(F)) u_fc (
    .clk      (clk),
    .rst      (rst),
    .clr_i    (bus.clr),
    .strobe_i (bus.wr_en),
    .done_o   (bus.frame_done)
  );

  assign bus.rd_valid = !empty;
  assign bus.rd_data  = mem_q[rp_q];
  assign bus.count    = count_q;
  assign bus.full     = full;
  assign bus.empty    = empty;
  assign bus.overflow = ovf_q;
endmodule

// File: tb/tb_npu_out_fifo.sv
// Directed bench for npu_out_fifo at N=2, DEPTH=8.
module tb_npu_out_fifo;
  import npu_pkg::*;

  localparam int N     = 2;
  localparam int DEPTH = 8;
  localparam int W     = acc_w(N);

  logic clk;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  npu_out_fifo_if #(.N(N), .DEPTH(DEPTH)) bus ();

  npu_out_fifo #(.N(N), .DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one edge; inputs change and outputs are sampled 1ns after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.clr      = 1'b0;
    bus.wr_en    = 1'b0;
    bus.wr_data  = '0;
    bus.rd_ready = 1'b0;
  endtask

  task automatic do_clr();
    bus.clr = 1'b1;
    tick();
    bus.clr = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1'b0;
    #3;
    checks++;
    if (bus.rd_valid !== 1'b0 || bus.empty !== 1'b1 || bus.full !== 1'b0 ||
        bus.count !== 4'd0 || bus.overflow !== 1'b0 || bus.frame_done !== 1'b0 ||
        bus.rd_data !== 17'h0) begin
      errors++;
      $display("FAIL reset_state: vld=%b emp=%b full=%b cnt=%0d ovf=%b fd=%b data=%h", bus.rd_valid,
               bus.empty, bus.full, bus.count, bus.overflow, bus.frame_done, bus.rd_data);
    end
    tick();
    rst = 1'b1;
    tick();
  endtask

  task automatic test_single();
    bus.wr_en = 1'b1; bus.wr_data = 17'h0123;
    tick();
    bus.wr_en = 1'b0;
    checks++;
    if (bus.rd_valid !== 1'b1 || bus.rd_data !== 17'h0123 || bus.count !== 4'd1) begin
      errors++;
      $display("FAIL single_write: vld=%b data=%h cnt=%0d want 1 0123 1", bus.rd_valid, bus.rd_data, bus.count);
    end
    bus.rd_ready = 1'b1;
    tick();
    bus.rd_ready = 1'b0;
    checks++;
    if (bus.empty !== 1'b1 || bus.rd_valid !== 1'b0) begin
      errors++;
      $display("FAIL single_read: empty=%b vld=%b want 1 0", bus.empty, bus.rd_valid);
    end
  endtask

  task automatic test_frame();
    logic [W-1:0] vals [4];
    vals[0] = 17'd5; vals[1] = 17'd0; vals[2] = 17'd7; vals[3] = 17'd9;
    do_clr();
    for (int i = 0; i < 4; i++) begin
      bus.wr_en = 1'b1; bus.wr_data = vals[i];
      tick();
      checks++;
      if (bus.frame_done !== (i == 3)) begin
        errors++;
        $display("FAIL frame_done_strobe%0d: got %b want %b", i, bus.frame_done, (i == 3));
      end
    end
    bus.wr_en = 1'b0;
    checks++;
    if (bus.count !== 4'd4) begin
      errors++;
      $display("FAIL frame_count: got %0d want 4", bus.count);
    end
    bus.rd_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (bus.rd_valid !== 1'b1 || bus.rd_data !== vals[i]) begin
        errors++;
        $display("FAIL frame_drain%0d: vld=%b data=%h want %h", i, bus.rd_valid, bus.rd_data, vals[i]);
      end
      tick();
      if (i == 0) begin
        checks++;
        if (bus.frame_done !== 1'b0) begin
          errors++;
          $display("FAIL frame_done_width: got %b want 0", bus.frame_done);
        end
      end
    end
    bus.rd_ready = 1'b0;
    checks++;
    if (bus.empty !== 1'b1) begin
      errors++;
      $display("FAIL frame_empty: got %b want 1", bus.empty);
    end
  endtask

  task automatic test_overflow();
    do_clr();
    for (int i = 0; i < DEPTH; i++) begin
      bus.wr_en = 1'b1; bus.wr_data = W'(10 + i);
      tick();
    end
    checks++;
    if (bus.full !== 1'b1 || bus.count !== 4'd8 || bus.overflow !== 1'b0) begin
      errors++;
      $display("FAIL fill: full=%b cnt=%0d ovf=%b want 1 8 0", bus.full, bus.count, bus.overflow);
    end
    bus.wr_data = 17'h1FF;
    tick();
    bus.wr_en = 1'b0;
    checks++;
    if (bus.overflow !== 1'b1 || bus.count !== 4'd8 || bus.rd_data !== 17'd10) begin
      errors++;
      $display("FAIL drop: ovf=%b cnt=%0d head=%h want 1 8 00a", bus.overflow, bus.count, bus.rd_data);
    end
    do_clr();
    checks++;
    if (bus.count !== 4'd0 || bus.overflow !== 1'b0 || bus.empty !== 1'b1) begin
      errors++;
      $display("FAIL clr: cnt=%0d ovf=%b emp=%b want 0 0 1", bus.count, bus.overflow, bus.empty);
    end
  endtask

  task automatic test_full_rw();
    logic [W-1:0] exp_w;
    do_clr();
    for (int i = 0; i < DEPTH; i++) begin
      bus.wr_en = 1'b1; bus.wr_data = W'(20 + i);
      tick();
    end
    bus.wr_data = 17'h99; bus.rd_ready = 1'b1;
    tick();
    bus.wr_en = 1'b0;
    checks++;
    if (bus.count !== 4'd8 || bus.overflow !== 1'b0 || bus.full !== 1'b1) begin
      errors++;
      $display("FAIL full_rw: cnt=%0d ovf=%b full=%b want 8 0 1", bus.count, bus.overflow, bus.full);
    end
    for (int i = 0; i < DEPTH; i++) begin
      exp_w = (i == DEPTH - 1) ? 17'h99 : W'(21 + i);
      checks++;
      if (bus.rd_valid !== 1'b1 || bus.rd_data !== exp_w) begin
        errors++;
        $display("FAIL full_rw_drain%0d: vld=%b data=%h want %h", i, bus.rd_valid, bus.rd_data, exp_w);
      end
      tick();
    end
    bus.rd_ready = 1'b0;
  endtask

  task automatic test_back_to_back();
    int pulses = 0;
    int bad_cnt = 0;
    do_clr();
    bus.rd_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      bus.wr_en = 1'b1; bus.wr_data = W'(100 + i);
      if (i > 0) begin
        checks++;
        if (bus.rd_valid !== 1'b1 || bus.rd_data !== W'(100 + i - 1)) begin
          errors++;
          $display("FAIL stream%0d: vld=%b data=%h want %h", i, bus.rd_valid, bus.rd_data, W'(100 + i - 1));
        end
      end
      tick();
      if (bus.count > 4'd1) bad_cnt++;
      if (bus.frame_done === 1'b1) pulses++;
    end
    bus.wr_en = 1'b0;
    checks++;
    if (bus.rd_valid !== 1'b1 || bus.rd_data !== W'(119)) begin
      errors++;
      $display("FAIL stream_last: vld=%b data=%h want 077", bus.rd_valid, bus.rd_data);
    end
    tick();
    bus.rd_ready = 1'b0;
    checks++;
    if (bad_cnt != 0 || bus.empty !== 1'b1) begin
      errors++;
      $display("FAIL stream_count: cycles_over_1=%0d emp=%b want 0 1", bad_cnt, bus.empty);
    end
    checks++;
    if (pulses != 5) begin
      errors++;
      $display("FAIL stream_frames: got %0d pulses want 5", pulses);
    end
  endtask

  task automatic test_reset_midframe();
    int pulses = 0;
    do_clr();
    for (int i = 0; i < 2; i++) begin
      bus.wr_en = 1'b1; bus.wr_data = W'(50 + i);
      tick();
    end
    bus.wr_en = 1'b0;
    rst = 1'b0;
    #1;
    checks++;
    if (bus.rd_valid !== 1'b0 || bus.empty !== 1'b1 || bus.full !== 1'b0 ||
        bus.count !== 4'd0 || bus.overflow !== 1'b0 || bus.frame_done !== 1'b0 ||
        bus.rd_data !== 17'h0) begin
      errors++;
      $display("FAIL midframe_reset: vld=%b emp=%b full=%b cnt=%0d ovf=%b fd=%b data=%h", bus.rd_valid,
               bus.empty, bus.full, bus.count, bus.overflow, bus.frame_done, bus.rd_data);
    end
    #1;
    rst = 1'b1;
    tick();
    bus.rd_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      bus.wr_en   = (i < 4);
      bus.wr_data = W'(60 + i);
      tick();
      if (bus.frame_done === 1'b1) pulses++;
    end
    bus.wr_en = 1'b0; bus.rd_ready = 1'b0;
    checks++;
    if (pulses != 1) begin
      errors++;
      $display("FAIL midframe_frames: got %0d pulses want 1", pulses);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_frame();
    test_overflow();
    test_full_rw();
    test_back_to_back();
    test_reset_midframe();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
